// File: rtl/ring_router_pkg.sv
// rtl/ring_router_pkg.sv - shared constants and packet helpers for the ring router
package ring_router_pkg;

  // Default packet layout
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_DIR_BIT = 30;
  localparam int DEF_HOP_LSB = 18;
  localparam int DEF_HOP_W   = 8;

  // Port indices, used for both input and output arrays
  localparam int CW  = 0;
  localparam int CCW = 1;
  localparam int PE  = 2;

  // Virtual channel indices
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [DEF_DATA_W-1:0] pkt_t;

  // One hop consumed: logical right shift of the hop field, everything else untouched
  function automatic pkt_t hop_shift(input pkt_t pkt);
    pkt_t r;
    r = pkt;
    r[DEF_HOP_LSB +: DEF_HOP_W] = pkt[DEF_HOP_LSB +: DEF_HOP_W] >> 1;
    return r;
  endfunction

endpackage

// File: rtl/ring_router_vc_rr_arb2.sv
// rtl/ring_router_vc_rr_arb2.sv - two-requester round-robin arbiter with shared pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // r_ptr=0 favours requester 0 (the ring input on ring outputs)
  logic r_ptr;

  // Grant the lone requester, or the favoured one when both ask
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer moves to the loser only after a contested grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_ptr <= 1'b0;
    else if (en && req == 2'b11)   r_ptr <= ~r_ptr;
  end

endmodule

// File: rtl/ring_router_vc.sv
// rtl/ring_router_vc.sv - bidirectional ring-node router with even/odd virtual channels
module ring_router_vc
  import ring_router_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIR_BIT = DEF_DIR_BIT,
  parameter int HOP_LSB = DEF_HOP_LSB,
  parameter int HOP_W   = DEF_HOP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cwsi,
  output logic              cwri,
  input  logic [DATA_W-1:0] cwdi,
  input  logic              ccwsi,
  output logic              ccwri,
  input  logic [DATA_W-1:0] ccwdi,
  input  logic              pesi,
  output logic              peri,
  input  logic [DATA_W-1:0] pedi,
  output logic              cwso,
  input  logic              cwro,
  output logic [DATA_W-1:0] cwdo,
  output logic              ccwso,
  input  logic              ccwro,
  output logic [DATA_W-1:0] ccwdo,
  output logic              peso,
  input  logic              pero,
  output logic [DATA_W-1:0] pedo,
  output logic              polarity
);

  // Links work on VC r_pol, the switch on VC ~r_pol, so they never share a buffer
  logic              r_pol;
  logic [1:0]        r_in_full  [3];
  logic [1:0]        r_out_full [3];
  logic [DATA_W-1:0] r_in_buf   [3][2];
  logic [DATA_W-1:0] r_out_buf  [3][2];
  logic              r_so       [3];
  logic [DATA_W-1:0] r_do       [3];

  logic              w_sv;
  logic              w_si   [3];
  logic              w_ri   [3];
  logic              w_ro   [3];
  logic [DATA_W-1:0] w_di   [3];
  logic              w_vld  [3];
  logic [DATA_W-1:0] w_pkt  [3];
  logic [DATA_W-1:0] w_fwd  [3];
  logic [1:0]        w_req  [3];
  logic [1:0]        w_gnt  [3];
  logic              w_en   [3];
  logic              w_take [3];
  logic [DATA_W-1:0] w_win  [3];

  assign w_sv = ~r_pol;

  assign w_si[CW]  = cwsi;
  assign w_si[CCW] = ccwsi;
  assign w_si[PE]  = pesi;
  assign w_di[CW]  = cwdi;
  assign w_di[CCW] = ccwdi;
  assign w_di[PE]  = pedi;
  assign w_ro[CW]  = cwro;
  assign w_ro[CCW] = ccwro;
  assign w_ro[PE]  = pero;

  assign cwri  = w_ri[CW];
  assign ccwri = w_ri[CCW];
  assign peri  = w_ri[PE];
  assign cwso  = r_so[CW];
  assign ccwso = r_so[CCW];
  assign peso  = r_so[PE];
  assign cwdo  = r_do[CW];
  assign ccwdo = r_do[CCW];
  assign pedo  = r_do[PE];
  assign polarity = r_pol;

  // Input readiness depends only on the link-side VC buffer
  always_comb begin
    for (int x = 0; x < 3; x++) w_ri[x] = ~r_in_full[x][r_pol];
  end

  // Switch-side view of each input; ring packets that keep going lose one hop
  always_comb begin
    for (int x = 0; x < 3; x++) begin
      w_vld[x] = r_in_full[x][w_sv];
      w_pkt[x] = r_in_buf[x][w_sv];
      w_fwd[x] = w_pkt[x];
    end
    for (int x = CW; x <= CCW; x++) begin
      if (w_pkt[x][HOP_LSB])
        w_fwd[x][HOP_LSB +: HOP_W] = w_pkt[x][HOP_LSB +: HOP_W] >> 1;
    end
  end

  // Requests per output: bit0 is the favoured-at-reset ring input
  always_comb begin
    w_req[CW]  = {w_vld[PE]  & ~w_pkt[PE][DIR_BIT],  w_vld[CW]  &  w_pkt[CW][HOP_LSB]};
    w_req[CCW] = {w_vld[PE]  &  w_pkt[PE][DIR_BIT],  w_vld[CCW] &  w_pkt[CCW][HOP_LSB]};
    w_req[PE]  = {w_vld[CCW] & ~w_pkt[CCW][HOP_LSB], w_vld[CW]  & ~w_pkt[CW][HOP_LSB]};
    for (int o = 0; o < 3; o++) w_en[o] = ~r_out_full[o][w_sv];
  end

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_arb
      rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req[g]),
        .en    (w_en[g]),
        .gnt   (w_gnt[g])
      );
    end
  endgenerate

  // Steer winning packets to outputs and free the inputs that won
  always_comb begin
    w_win[CW]   = w_gnt[CW][0]  ? w_fwd[CW]  : w_fwd[PE];
    w_win[CCW]  = w_gnt[CCW][0] ? w_fwd[CCW] : w_fwd[PE];
    w_win[PE]   = w_gnt[PE][0]  ? w_fwd[CW]  : w_fwd[CCW];
    w_take[CW]  = w_gnt[CW][0]  | w_gnt[PE][0];
    w_take[CCW] = w_gnt[CCW][0] | w_gnt[PE][1];
    w_take[PE]  = w_gnt[CW][1]  | w_gnt[CCW][1];
  end

  // Phase, occupancy flags and output link registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pol <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_in_full[i]  <= '0;
        r_out_full[i] <= '0;
        r_so[i]       <= 1'b0;
        r_do[i]       <= '0;
      end
    end else begin
      r_pol <= ~r_pol;
      for (int i = 0; i < 3; i++) begin
        if (w_si[i] && w_ri[i]) r_in_full[i][r_pol] <= 1'b1;
        if (w_take[i])          r_in_full[i][w_sv]  <= 1'b0;
        if (w_gnt[i] != 2'b00)  r_out_full[i][w_sv] <= 1'b1;
        if (r_out_full[i][r_pol] && w_ro[i]) begin
          r_so[i]              <= 1'b1;
          r_do[i]              <= r_out_buf[i][r_pol];
          r_out_full[i][r_pol] <= 1'b0;
        end else begin
          r_so[i] <= 1'b0;
        end
      end
    end
  end

  // Packet storage carries no reset; occupancy flags qualify it
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_si[i] && w_ri[i]) r_in_buf[i][r_pol]  <= w_di[i];
      if (w_gnt[i] != 2'b00)  r_out_buf[i][w_sv]  <= w_win[i];
    end
  end

endmodule

// File: tb/tb_ring_router_vc.sv
// tb/tb_ring_router_vc.sv - self-checking bench for ring_router_vc
module tb_ring_router_vc;

  localparam int NP = 3;

  typedef struct { logic [63:0] d; int src; logic vc; } ent_t;
  typedef struct { int src; logic [7:0] hop; logic dir; int dst; logic [7:0] ehop; } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        si [NP];
  logic        ri [NP];
  logic [63:0] di [NP];
  logic        so [NP];
  logic        ro [NP];
  logic [63:0] dout [NP];
  logic        polarity;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          n_acc = 0;
  int          tagc  = 0;
  logic        m_pol = 1'b0;
  bit          rand_ro = 1'b0;
  logic        pend [NP];
  logic [63:0] pend_d [NP];
  int          gen_left [NP];
  int          mode [NP];
  ent_t        expq [NP][$];
  int          src_log [$];
  vec_t        tbl [8];

  always #5 clk = ~clk;

  ring_router_vc dut (
    .clk (clk), .reset (reset),
    .cwsi (si[0]), .cwri (ri[0]), .cwdi (di[0]),
    .ccwsi (si[1]), .ccwri (ri[1]), .ccwdi (di[1]),
    .pesi (si[2]), .peri (ri[2]), .pedi (di[2]),
    .cwso (so[0]), .cwro (ro[0]), .cwdo (dout[0]),
    .ccwso (so[1]), .ccwro (ro[1]), .ccwdo (dout[1]),
    .peso (so[2]), .pero (ro[2]), .pedo (dout[2]),
    .polarity (polarity)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic dir, input logic [7:0] hop, input logic [15:0] tag);
    logic [63:0] p;
    p = 64'hC0DE_0000_0000_0000;
    p[47:32] = tag ^ 16'h5A5A;
    p[15:0]  = tag;
    p[25:18] = hop;
    p[30]    = dir;
    return p;
  endfunction

  // Reference routing: where a packet from src should leave and what it looks like then
  function automatic void route(input int src, input logic [63:0] d, output int dst, output logic [63:0] e);
    int hop;
    hop = int'(d[25:18]);
    e = d;
    if (src == 2) dst = d[30] ? 1 : 0;
    else if (hop % 2 == 0) dst = 2;
    else begin
      dst = src;
      e[25:18] = 8'(hop / 2);
    end
  endfunction

  // Output must be expected on that port, in that VC, and not overtake an older packet of the same input VC
  task automatic score(input int o, input logic [63:0] d);
    int idx;
    bit ok;
    idx = -1;
    for (int i = 0; i < expq[o].size(); i++)
      if (idx < 0 && expq[o][i].d == d) idx = i;
    if (idx < 0) begin
      chk(1'b0, $sformatf("route_port%0d", o), d, 64'h0);
      return;
    end
    ok = (expq[o][idx].vc == ~m_pol);
    for (int j = 0; j < idx; j++)
      if (expq[o][j].src == expq[o][idx].src && expq[o][j].vc == expq[o][idx].vc) ok = 1'b0;
    if (o == 0) src_log.push_back(expq[o][idx].src);
    chk(ok, $sformatf("order_vc_port%0d", o), d, expq[o][idx].d);
    expq[o].delete(idx);
  endtask

  task automatic cycle();
    int dst;
    logic [63:0] e;
    @(negedge clk);
    m_pol = ~m_pol;
    chk(polarity == m_pol, "polarity", 64'(polarity), 64'(m_pol));
    for (int o = 0; o < NP; o++)
      if (so[o]) begin
        n_out++;
        score(o, dout[o]);
      end
    for (int x = 0; x < NP; x++) begin
      if (!pend[x] && gen_left[x] > 0 && (mode[x] != 0 || $urandom_range(0, 3) != 0)) begin
        if (mode[x] == 0) begin
          pend_d[x] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), {4'(x + 1), 12'(tagc)});
          pend_d[x][63:48] = 16'($urandom_range(0, 65535));
        end else begin
          pend_d[x] = mk(1'b0, 8'h01, {4'(x + 1), 12'(tagc)});
        end
        tagc++;
        pend[x] = 1'b1;
        gen_left[x]--;
      end
      si[x] = pend[x];
      di[x] = pend_d[x];
      if (pend[x] && ri[x]) begin
        route(x, pend_d[x], dst, e);
        expq[dst].push_back('{e, x, m_pol});
        n_acc++;
        pend[x] = 1'b0;
      end
    end
    if (rand_ro)
      for (int o = 0; o < NP; o++) ro[o] = ($urandom_range(0, 3) != 0);
  endtask

  function automatic int backlog();
    int n;
    n = 0;
    for (int x = 0; x < NP; x++) n += expq[x].size() + int'(pend[x]) + gen_left[x];
    return n;
  endfunction

  task automatic drain(input int limit, input string name);
    int k;
    k = 0;
    while (k < limit && backlog() != 0) begin
      cycle();
      k++;
    end
    chk(backlog() == 0, name, 64'(backlog()), 64'h0);
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int o = 0; o < NP; o++) begin
      chk(so[o] == 1'b0, "reset_so", 64'(so[o]), 64'h0);
      chk(dout[o] == 64'h0, "reset_do", dout[o], 64'h0);
    end
    chk(polarity == 1'b0, "reset_polarity", 64'(polarity), 64'h0);
    for (int x = 0; x < NP; x++) begin
      expq[x].delete();
      pend[x] = 1'b0;
      si[x] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pol = 1'b0;
    for (int x = 0; x < NP; x++) chk(ri[x] == 1'b1, "ri_after_reset", 64'(ri[x]), 64'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] pkt;
    logic [63:0] ex;
    int n0;
    int a0;
    int bad;
    int others;
    int k;

    for (int x = 0; x < NP; x++) begin
      si[x] = 1'b0; di[x] = '0; ro[x] = 1'b1;
      pend[x] = 1'b0; pend_d[x] = '0; gen_left[x] = 0; mode[x] = 0;
    end

    mid_reset();

    // Single packets through an idle router: route, hop arithmetic and two-edge latency
    tbl[0] = '{0, 8'h03, 1'b0, 0, 8'h01};
    tbl[1] = '{1, 8'h02, 1'b0, 2, 8'h02};
    tbl[2] = '{2, 8'h05, 1'b1, 1, 8'h05};
    tbl[3] = '{2, 8'h05, 1'b0, 0, 8'h05};
    tbl[4] = '{0, 8'h00, 1'b0, 2, 8'h00};
    tbl[5] = '{1, 8'hFF, 1'b1, 1, 8'h7F};
    tbl[6] = '{0, 8'h80, 1'b1, 2, 8'h80};
    tbl[7] = '{1, 8'h01, 1'b0, 1, 8'h00};
    for (int i = 0; i < 8; i++) begin
      repeat (2) cycle();
      pkt = mk(tbl[i].dir, tbl[i].hop, {4'hE, 12'(i)});
      ex  = mk(tbl[i].dir, tbl[i].ehop, {4'hE, 12'(i)});
      pend[tbl[i].src] = 1'b1;
      pend_d[tbl[i].src] = pkt;
      cycle();
      chk(pend[tbl[i].src] == 1'b0, $sformatf("vec%0d_accept", i), 64'(pend[tbl[i].src]), 64'h0);
      cycle();
      cycle();
      chk(!so[0] && !so[1] && !so[2], $sformatf("vec%0d_early", i), {61'h0, so[2], so[1], so[0]}, 64'h0);
      cycle();
      chk(so[tbl[i].dst] == 1'b1 && dout[tbl[i].dst] == ex, $sformatf("vec%0d_out", i), dout[tbl[i].dst], ex);
      others = 0;
      for (int o = 0; o < NP; o++) if (o != tbl[i].dst && so[o]) others++;
      chk(others == 0, $sformatf("vec%0d_other_ports", i), 64'(others), 64'h0);
    end
    repeat (3) cycle();

    // Back-pressure on cw output while cw input streams
    n0 = n_out;
    a0 = n_acc;
    ro[0] = 1'b0;
    mode[0] = 1;
    gen_left[0] = 6;
    repeat (10) cycle();
    chk(n_out == n0, "bp_no_send", 64'(n_out - n0), 64'h0);
    chk(n_acc - a0 == 4, "bp_fill_count", 64'(n_acc - a0), 64'h4);
    chk(ri[0] == 1'b0, "bp_ri_low_a", 64'(ri[0]), 64'h0);
    cycle();
    chk(ri[0] == 1'b0, "bp_ri_low_b", 64'(ri[0]), 64'h0);
    ro[0] = 1'b1;
    drain(80, "bp_drain");
    chk(n_out - n0 == 6, "bp_total_out", 64'(n_out - n0), 64'h6);
    mode[0] = 0;
    repeat (3) cycle();

    // cw and pe both streaming into the cw output: sources must alternate
    src_log.delete();
    n0 = n_out;
    a0 = n_acc;
    mode[0] = 1;
    mode[2] = 1;
    gen_left[0] = 40;
    gen_left[2] = 40;
    k = 0;
    while (k < 300 && src_log.size() < 16) begin
      cycle();
      k++;
    end
    chk(src_log.size() >= 16, "alt_count", 64'(src_log.size()), 64'd16);
    bad = 0;
    for (int i = 1; i < 16 && i < src_log.size(); i++)
      if (src_log[i] == src_log[i - 1]) bad++;
    chk(bad == 0, "alt_sources", 64'(bad), 64'h0);
    gen_left[0] = 0;
    gen_left[2] = 0;
    drain(200, "alt_drain");
    chk(n_out - n0 == n_acc - a0, "alt_conservation", 64'(n_out - n0), 64'(n_acc - a0));
    mode[0] = 0;
    mode[2] = 0;

    // Random traffic with random back-pressure, interrupted by a reset
    rand_ro = 1'b1;
    for (int x = 0; x < NP; x++) gen_left[x] = 1000;
    repeat (150) cycle();
    mid_reset();
    repeat (250) cycle();
    for (int x = 0; x < NP; x++) gen_left[x] = 0;
    rand_ro = 1'b0;
    for (int o = 0; o < NP; o++) ro[o] = 1'b1;
    drain(400, "random_drain");
    n0 = n_out;
    repeat (6) cycle();
    chk(n_out == n0, "idle_quiet", 64'(n_out - n0), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
